// File: rtl/tagdv_lookup_pkg.sv
// Shared types for the 2-way data cache tag path: TagDV entry layout,
// geometry constants and the lookup/miss-control state encoding.
package tagdv_lookup_pkg;

  localparam int TAG_W   = 20;
  localparam int INDEX_W = 8;
  localparam int WAYS    = 2;
  localparam int SETS    = 1 << INDEX_W;
  localparam int TDV_W   = TAG_W + 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             dirty;
    logic             valid;
  } tagdv_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_UPDATE
  } state_t;

  function automatic logic [WAYS-1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tagdv_lookup.sv
// Tag lookup and miss control for the 2-way data cache: drives the TagDV RAM
// read address a cycle ahead, compares tags, tracks LRU and owns all TagDV writes.
module tagdv_lookup
  import tagdv_lookup_pkg::*;
(
  input  logic               clka,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               req_wr,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_way,
  output logic               miss_valid,
  input  logic               miss_ready,
  output logic               miss_way,
  output logic [TAG_W-1:0]   miss_victim_tag,
  output logic               miss_victim_dirty,
  input  logic               refill_done,
  output logic [INDEX_W-1:0] tdv_addrb,
  input  logic [TDV_W-1:0]   tdv_doutb0,
  input  logic [TDV_W-1:0]   tdv_doutb1,
  output logic [INDEX_W-1:0] tdv_addra,
  output logic [TDV_W-1:0]   tdv_dina,
  output logic [WAYS-1:0]    tdv_wea
);

  state_t             r_state, w_state_nxt;
  logic [INDEX_W-1:0] r_sweep;
  logic [SETS-1:0]    r_lru;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic               r_wr;
  logic               r_victim;
  logic [TAG_W-1:0]   r_victim_tag;
  logic               r_victim_dirty;

  tagdv_t w_rd0, w_rd1, w_vic_entry;
  logic   w_hit0, w_hit1, w_hit, w_hit_way, w_hit_dirty, w_victim;

  assign w_rd0  = tdv_doutb0;
  assign w_rd1  = tdv_doutb1;
  assign w_hit0 = w_rd0.valid && (w_rd0.tag == r_tag);
  assign w_hit1 = w_rd1.valid && (w_rd1.tag == r_tag);
  assign w_hit  = w_hit0 || w_hit1;
  // Way 0 wins on a (theoretically impossible) double hit.
  assign w_hit_way   = !w_hit0;
  assign w_hit_dirty = w_hit0 ? w_rd0.dirty : w_rd1.dirty;
  assign w_victim    = !w_rd0.valid ? 1'b0 : (!w_rd1.valid ? 1'b1 : r_lru[r_index]);
  assign w_vic_entry = w_victim ? w_rd1 : w_rd0;

  assign miss_valid        = (r_state == S_MISS);
  assign miss_way          = r_victim;
  assign miss_victim_tag   = r_victim_tag;
  assign miss_victim_dirty = r_victim_dirty;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case leaves a value held, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_hit    = 1'b0;
    resp_way    = 1'b0;
    tdv_addrb   = r_index;
    tdv_addra   = r_index;
    tdv_dina    = '0;
    tdv_wea     = '0;
    case (r_state)
      S_INIT: begin
        tdv_addra = r_sweep;
        tdv_wea   = 2'b11;
        if (r_sweep == '1) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        tdv_addrb = req_index;
        if (req_valid) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          resp_valid  = 1'b1;
          resp_hit    = 1'b1;
          resp_way    = w_hit_way;
          req_ready   = 1'b1;
          tdv_addrb   = req_index;
          if (r_wr && !w_hit_dirty) begin
            tdv_dina = {r_tag, 1'b1, 1'b1};
            tdv_wea  = way_onehot(w_hit_way);
          end
          w_state_nxt = req_valid ? S_LOOKUP : S_IDLE;
        end else begin
          w_state_nxt = S_MISS;
        end
      end
      S_MISS:   if (miss_ready)  w_state_nxt = S_REFILL;
      S_REFILL: if (refill_done) w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        tdv_dina    = {r_tag, r_wr, 1'b1};
        tdv_wea     = way_onehot(r_victim);
        resp_valid  = 1'b1;
        resp_way    = r_victim;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
    // The state register sits in INIT while reset is held; keep the RAMs untouched.
    if (rst) tdv_wea = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the LRU array is plain flops, not RAM, so it can and does take the
  // asynchronous reset; the TagDV RAMs are cleared by the INIT sweep instead.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state        <= S_INIT;
      r_sweep        <= '0;
      r_lru          <= '0;
      r_index        <= '0;
      r_tag          <= '0;
      r_wr           <= 1'b0;
      r_victim       <= 1'b0;
      r_victim_tag   <= '0;
      r_victim_dirty <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_sweep <= r_sweep + 1'b1;
      if (req_valid && req_ready) begin
        r_index <= req_index;
        r_tag   <= req_tag;
        r_wr    <= req_wr;
      end
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          r_lru[r_index] <= !w_hit_way;
        end else begin
          r_victim       <= w_victim;
          r_victim_tag   <= w_vic_entry.tag;
          r_victim_dirty <= w_vic_entry.valid && w_vic_entry.dirty;
        end
      end
      if (r_state == S_UPDATE) r_lru[r_index] <= !r_victim;
    end
  end

endmodule

// File: tb/tb_tagdv_lookup.sv
// Scoreboard bench for tagdv_lookup: behavioural 2-way cache model predicts
// responses and miss hand-offs; a monitor pops and compares them.
module tb_tagdv_lookup;
  import tagdv_lookup_pkg::*;

  logic               clka = 1'b0;
  logic               rst  = 1'b1;
  logic               req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [INDEX_W-1:0] req_index = '0;
  logic [TAG_W-1:0]   req_tag = '0;
  logic               resp_valid, resp_hit, resp_way;
  logic               miss_valid, miss_ready = 1'b0, miss_way, miss_victim_dirty;
  logic [TAG_W-1:0]   miss_victim_tag;
  logic               refill_done = 1'b0;
  logic [INDEX_W-1:0] tdv_addrb, tdv_addra;
  logic [TDV_W-1:0]   tdv_doutb0, tdv_doutb1, tdv_dina;
  logic [WAYS-1:0]    tdv_wea;

  always #5 clka = ~clka;

  tagdv_lookup dut (
    .clka(clka), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_wr(req_wr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_way(miss_way),
    .miss_victim_tag(miss_victim_tag), .miss_victim_dirty(miss_victim_dirty),
    .refill_done(refill_done),
    .tdv_addrb(tdv_addrb), .tdv_doutb0(tdv_doutb0), .tdv_doutb1(tdv_doutb1),
    .tdv_addra(tdv_addra), .tdv_dina(tdv_dina), .tdv_wea(tdv_wea)
  );

  // Way RAMs as the parent provides them: registered read address, combinational array read.
  logic [TDV_W-1:0]   ram0 [SETS];
  logic [TDV_W-1:0]   ram1 [SETS];
  logic [INDEX_W-1:0] raddr = '0;
  always @(posedge clka) begin
    if (tdv_wea[0]) ram0[tdv_addra] <= tdv_dina;
    if (tdv_wea[1]) ram1[tdv_addra] <= tdv_dina;
    raddr <= tdv_addrb;
  end
  assign tdv_doutb0 = ram0[raddr];
  assign tdv_doutb1 = ram1[raddr];

  int cyc = 0;
  always @(posedge clka) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit hit; bit way; } resp_t;
  typedef struct { bit way; logic [TAG_W-1:0] tag; bit dirty; } miss_t;

  logic [TAG_W-1:0] m_tag   [2][SETS];
  bit               m_dirty [2][SETS];
  bit               m_valid [2][SETS];
  bit               m_lru   [SETS];   // way to evict next in each set
  resp_t            exp_resp[$];
  miss_t            exp_miss[$];

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < SETS; i++) begin
        m_tag[w][i] = '0; m_dirty[w][i] = 0; m_valid[w][i] = 0;
      end
    for (int i = 0; i < SETS; i++) m_lru[i] = 0;
    exp_resp.delete();
    exp_miss.delete();
  endfunction

  function automatic void model_issue(input int idx, input logic [TAG_W-1:0] tag, input bit wr);
    int w = -1;
    int v;
    for (int k = 0; k < 2; k++)
      if (w < 0 && m_valid[k][idx] && m_tag[k][idx] == tag) w = k;
    if (w >= 0) begin
      exp_resp.push_back('{hit: 1'b1, way: (w == 1)});
      if (wr) m_dirty[w][idx] = 1;
      m_lru[idx] = (w == 0);
    end else begin
      if (!m_valid[0][idx])      v = 0;
      else if (!m_valid[1][idx]) v = 1;
      else                       v = m_lru[idx] ? 1 : 0;
      exp_miss.push_back('{way: (v == 1), tag: m_tag[v][idx],
                           dirty: m_valid[v][idx] && m_dirty[v][idx]});
      exp_resp.push_back('{hit: 1'b0, way: (v == 1)});
      m_tag[v][idx] = tag; m_dirty[v][idx] = wr; m_valid[v][idx] = 1;
      m_lru[idx] = (v == 0);
    end
  endfunction

  // ---------------- monitor ----------------
  int               resp_cyc_q[$];
  logic [WAYS-1:0]  resp_wea_q[$];
  logic [TDV_W-1:0] resp_dina_q[$];
  miss_t            last_miss;
  resp_t            mon_r;
  miss_t            mon_m;
  bit               hold_pending = 0;
  logic [TAG_W+1:0] held;

  always @(negedge clka) begin
    if (!rst) begin
      if (resp_valid) begin
        check("resp_with_miss", miss_valid, 1'b0);
        resp_cyc_q.push_back(cyc);
        resp_wea_q.push_back(tdv_wea);
        resp_dina_q.push_back(tdv_dina);
        if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          mon_r = exp_resp.pop_front();
          check("resp_hit", resp_hit, mon_r.hit);
          check("resp_way", resp_way, mon_r.way);
        end
      end
      if (miss_valid) begin
        if (hold_pending)
          check("miss_stable", {miss_way, miss_victim_tag, miss_victim_dirty}, held);
        if (miss_ready) begin
          hold_pending = 0;
          last_miss = '{way: miss_way, tag: miss_victim_tag, dirty: miss_victim_dirty};
          if (exp_miss.size() == 0) check("miss_unexpected", 1, 0);
          else begin
            mon_m = exp_miss.pop_front();
            check("miss_way", miss_way, mon_m.way);
            check("miss_tag", miss_victim_tag, mon_m.tag);
            check("miss_dirty", miss_victim_dirty, mon_m.dirty);
          end
        end else begin
          hold_pending = 1;
          held = {miss_way, miss_victim_tag, miss_victim_dirty};
        end
      end else begin
        hold_pending = 0;
      end
    end
  end

  // Downstream refill unit: random handshake timing, stray refill_done pulses included.
  bit auto_resp = 1;
  initial forever begin
    @(posedge clka);
    #2;
    if (auto_resp) begin
      miss_ready  = ($urandom_range(0, 2) == 0);
      refill_done = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver helpers ----------------
  int acc_cyc;

  task automatic do_req(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                        input bit wr, output int waits);
    bit ok = 0;
    waits = 0;
    @(negedge clka);
    req_valid = 1'b1; req_index = idx; req_tag = tag; req_wr = wr;
    while (!ok) begin
      #1;
      ok = req_ready;
      @(posedge clka);
      if (!ok) begin
        waits++;
        if (waits > 1000) begin
          check("req_accept_timeout", 1, 0);
          req_valid = 1'b0;
          return;
        end
        @(negedge clka);
      end
    end
    model_issue(int'(idx), tag, wr);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic end_req();
    @(negedge clka);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_resp.size() + exp_miss.size()) != 0 && n < 2000) begin
      @(negedge clka);
      n++;
    end
    check("drain", exp_resp.size() + exp_miss.size(), 0);
  endtask

  task automatic clear_logs();
    resp_cyc_q.delete(); resp_wea_q.delete(); resp_dina_q.delete();
  endtask

  // Called at the negedge where rst has just been released.
  task automatic run_sweep(input string nm);
    int wcnt = 0, addr_err = 0, dina_err = 0, rise = -1;
    for (int c = 0; c < 400 && rise < 0; c++) begin
      #1;
      if (tdv_wea != 2'b00) begin
        if (tdv_wea != 2'b11 || tdv_addra != wcnt[INDEX_W-1:0]) addr_err++;
        if (tdv_dina != '0) dina_err++;
        wcnt++;
      end
      if (req_ready) rise = c;
      @(negedge clka);
    end
    check({nm, "_sweep_cycles"}, wcnt, 256);
    check({nm, "_sweep_addr"}, addr_err, 0);
    check({nm, "_sweep_dina"}, dina_err, 0);
    check({nm, "_ready_rise"}, rise, 256);
  endtask

  task automatic ram_compare();
    logic [TDV_W-1:0] act;
    for (int i = 0; i < SETS; i++)
      for (int w = 0; w < 2; w++) begin
        act = (w == 1) ? ram1[i] : ram0[i];
        check($sformatf("ram_w%0d_i%0h", w, i), act, {m_tag[w][i], m_dirty[w][i], m_valid[w][i]});
      end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, w2, w3;
    logic [INDEX_W-1:0] ridx;
    logic [TAG_W-1:0]   rtag;

    model_reset();
    repeat (3) @(posedge clka);
    @(negedge clka);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_way", resp_way, 0);
    check("rst_miss_valid", miss_valid, 0);
    check("rst_wea", tdv_wea, 0);
    check("rst_dina", tdv_dina, 0);
    @(negedge clka);
    rst = 1'b0;
    run_sweep("init");

    // Cold miss then repeated read.
    clear_logs();
    do_req(8'h12, 20'hABCDE, 0, w0); end_req(); drain();
    check("cold_miss_way", last_miss.way, 0);
    check("cold_miss_dirty", last_miss.dirty, 0);
    check("cold_update_wea", resp_wea_q.size() > 0 ? resp_wea_q[0] : 2'b00, 2'b01);
    check("cold_update_dina", resp_dina_q.size() > 0 ? resp_dina_q[0] : '0, {20'hABCDE, 2'b01});
    clear_logs();
    do_req(8'h12, 20'hABCDE, 0, w0); end_req(); drain();
    check("hit_latency", resp_cyc_q.size() > 0 ? resp_cyc_q[0] : -1, acc_cyc);

    // Store-hit to clean line, read straight after, store again to the now-dirty line.
    clear_logs();
    do_req(8'h12, 20'hABCDE, 1, w0);
    do_req(8'h12, 20'hABCDE, 0, w1);
    do_req(8'h12, 20'hABCDE, 1, w2);
    end_req(); drain();
    check("store_seq_resps", resp_wea_q.size(), 3);
    check("store_no_stall", w1 + w2, 0);
    check("store_mark_wea", resp_wea_q[0], 2'b01);
    check("store_mark_dina", resp_dina_q[0], {20'hABCDE, 2'b11});
    check("read_no_write", resp_wea_q[1], 2'b00);
    check("dirty_store_no_write", resp_wea_q[2], 2'b00);

    // Fill way 1, touch way 0, then evict the LRU way 1.
    do_req(8'h12, 20'h11111, 1, w0); end_req(); drain();
    do_req(8'h12, 20'hABCDE, 0, w0); end_req(); drain();
    do_req(8'h12, 20'h22222, 0, w0); end_req(); drain();
    check("evict_way", last_miss.way, 1);
    check("evict_tag", last_miss.tag, 20'h11111);
    check("evict_dirty", last_miss.dirty, 1);

    // Four back-to-back hits across two sets.
    do_req(8'h34, 20'h33333, 0, w0); end_req(); drain();
    clear_logs();
    do_req(8'h12, 20'h22222, 0, w0);
    do_req(8'h34, 20'h33333, 0, w1);
    do_req(8'h12, 20'hABCDE, 0, w2);
    do_req(8'h34, 20'h33333, 0, w3);
    end_req(); drain();
    check("b2b_waits", w0 + w1 + w2 + w3, 0);
    check("b2b_resps", resp_cyc_q.size(), 4);
    check("b2b_span", resp_cyc_q[3] - resp_cyc_q[0], 3);

    // Random traffic over a few sets and tags.
    for (int n = 0; n < 300; n++) begin
      ridx = 8'h40 + 8'($urandom_range(0, 5));
      rtag = 20'h50000 + 20'($urandom_range(0, 3));
      do_req(ridx, rtag, bit'($urandom_range(0, 1)), w0);
      if ($urandom_range(0, 3) == 0) begin
        end_req();
        repeat ($urandom_range(0, 2)) @(negedge clka);
      end
    end
    end_req(); drain();
    ram_compare();

    // Reset while waiting for refill_done.
    auto_resp = 0;
    @(posedge clka); #3;
    miss_ready = 1'b0; refill_done = 1'b0;
    do_req(8'h77, 20'h77777, 1, w0); end_req();
    for (int n = 0; n < 20 && !miss_valid; n++) @(negedge clka);
    check("rst_test_miss_seen", miss_valid, 1);
    @(posedge clka); #3; miss_ready = 1'b1;
    @(posedge clka); #3; miss_ready = 1'b0;
    repeat (3) @(negedge clka);
    rst = 1'b1;
    #1;
    check("midrst_miss_valid", miss_valid, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_wea", tdv_wea, 0);
    refill_done = 1'b1;
    @(negedge clka); #1;
    check("midrst_wea_hold", tdv_wea, 0);
    refill_done = 1'b0;
    model_reset();
    @(negedge clka);
    rst = 1'b0;
    run_sweep("rerun");
    auto_resp = 1;
    ram_compare();
    do_req(8'h77, 20'h77777, 0, w0); end_req(); drain();
    check("post_rst_miss_dirty", last_miss.dirty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
